// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: round-robin sequencer for divider ratio changes.
// Gates clk_en around each ratio load, then acks the winning requester.
module clk_div_ctrl #(
  parameter int div_ratio_wd  = 8,
  parameter int num_req       = 4,
  parameter int default_ratio = 2,
  parameter int gate_cycles   = 2,
  parameter int settle_cycles = 4
) (
  input  logic                             clk_ref,
  input  logic                             rst_n,
  input  logic [num_req-1:0]               req,
  input  logic [num_req*div_ratio_wd-1:0]  req_ratio,
  output logic [num_req-1:0]               grant,
  output logic                             err,
  output logic [div_ratio_wd-1:0]          div_ratio,
  output logic                             clk_en,
  output logic                             busy
);

  localparam int IW = $clog2(num_req);
  localparam int MC = (gate_cycles > settle_cycles) ?
                      gate_cycles : settle_cycles;
  localparam int CW = $clog2(MC + 1);
  localparam logic [num_req-1:0] ONE = num_req'(1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_GATE,
    S_LOAD,
    S_SETTLE,
    S_ACK
  } state_t;

  state_t                    r_state, w_state_n;
  logic [IW-1:0]             r_ptr, w_ptr_n;
  logic [IW-1:0]             r_win, w_win_n;
  logic [div_ratio_wd-1:0]   r_ratio, w_ratio_n;
  logic                      r_rej, w_rej_n;
  logic [CW-1:0]             r_cnt, w_cnt_n;
  logic [div_ratio_wd-1:0]   r_div, w_div_n;
  logic                      r_en, w_en_n;
  logic [num_req-1:0]        r_grant, w_grant_n;
  logic                      r_err, w_err_n;
  logic                      r_busy, w_busy_n;

  logic [IW:0]               w_pick;
  logic                      w_hit;
  logic [IW-1:0]             w_win;
  logic [div_ratio_wd-1:0]   w_wratio;

  function automatic logic [IW:0] f_pick(
    input logic [num_req-1:0] rq,
    input logic [IW-1:0]      ptr
  );
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int k = num_req - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % num_req;
      if (rq[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  assign w_pick   = f_pick(req, r_ptr);
  assign w_hit    = w_pick[IW];
  assign w_win    = w_pick[IW-1:0];
  assign w_wratio =
    req_ratio[int'(w_win)*div_ratio_wd +: div_ratio_wd];

  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_win_n   = r_win;
    w_ratio_n = r_ratio;
    w_rej_n   = r_rej;
    w_cnt_n   = r_cnt;
    w_div_n   = r_div;
    w_en_n    = r_en;
    w_grant_n = '0;
    w_err_n   = 1'b0;
    w_busy_n  = r_busy;
    unique case (r_state)
      S_BOOT: begin
        w_state_n = S_IDLE;
        w_en_n    = 1'b1;
      end
      S_IDLE: begin
        if (w_hit) begin
          w_win_n   = w_win;
          w_ratio_n = w_wratio;
          w_busy_n  = 1'b1;
          w_rej_n   = (w_wratio == '0);
          // no-op/reject hold one cycle so the ack lands on E1
          if (w_wratio == '0 || w_wratio == r_div) begin
            w_state_n = S_SETTLE;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_GATE;
            w_cnt_n   = CW'(gate_cycles - 1);
            w_en_n    = 1'b0;
          end
        end
      end
      S_GATE: begin
        if (r_cnt == '0) begin
          w_state_n = S_LOAD;
          w_div_n   = r_ratio;
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_LOAD: begin
        w_state_n = S_SETTLE;
        w_en_n    = 1'b1;
        w_cnt_n   = CW'(settle_cycles - 1);
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_n = S_ACK;
          w_grant_n = ONE << r_win;
          w_err_n   = r_rej;
          w_ptr_n   = (r_win == IW'(num_req - 1)) ?
                      '0 : r_win + IW'(1);
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
      S_ACK: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end
      default: w_state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_ptr   <= '0;
      r_win   <= '0;
      r_ratio <= '0;
      r_rej   <= 1'b0;
      r_cnt   <= '0;
      r_div   <= div_ratio_wd'(default_ratio);
      r_en    <= 1'b0;
      r_grant <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_win   <= w_win_n;
      r_ratio <= w_ratio_n;
      r_rej   <= w_rej_n;
      r_cnt   <= w_cnt_n;
      r_div   <= w_div_n;
      r_en    <= w_en_n;
      r_grant <= w_grant_n;
      r_err   <= w_err_n;
      r_busy  <= w_busy_n;
    end
  end

  assign grant     = r_grant;
  assign err       = r_err;
  assign div_ratio = r_div;
  assign clk_en    = r_en;
  assign busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: timeline model plus directed checks for clk_div_ctrl.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int G = 2;
  localparam int S = 4;
  localparam int N = 4;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  ratios [4];
  logic [31:0] req_ratio;
  logic [3:0]  grant;
  logic        err;
  logic [7:0]  div_ratio;
  logic        clk_en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_ref = ~clk_ref;

  assign req_ratio = {ratios[3], ratios[2], ratios[1], ratios[0]};

  clk_div_ctrl dut (
    .clk_ref   (clk_ref),
    .rst_n     (rst_n),
    .req       (req),
    .req_ratio (req_ratio),
    .grant     (grant),
    .err       (err),
    .div_ratio (div_ratio),
    .clk_en    (clk_en),
    .busy      (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Model: time since the sampling edge decides every output.
  int         m_t, m_T, m_win, m_ptr;
  bit         m_act, m_boot, m_short, m_rej;
  logic [7:0] m_ratio, m_div;
  bit         m_en, m_busy, m_err;
  logic [3:0] m_grant;

  always @(posedge clk_ref or negedge rst_n) begin : model
    int         w;
    int         nt;
    logic [7:0] rt;
    bit         sh;
    if (!rst_n) begin
      m_div <= 8'd2; m_en <= 0; m_grant <= '0; m_err <= 0;
      m_busy <= 0; m_ptr <= 0; m_act <= 0; m_boot <= 0;
    end else if (!m_boot) begin
      m_boot <= 1; m_en <= 1;
    end else if (m_act) begin
      nt = m_t + 1;
      m_t <= nt;
      m_grant <= (nt == m_T) ? 4'(1 << m_win) : 4'd0;
      m_err   <= (nt == m_T) && m_rej;
      if (!m_short && nt == G) m_div <= m_ratio;
      if (!m_short && nt == G + 1) m_en <= 1;
      if (nt == m_T) m_ptr <= (m_win + 1) % N;
      if (nt == m_T + 1) begin m_act <= 0; m_busy <= 0; end
    end else if (req != 0) begin
      w = m_ptr;
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      rt = ratios[w];
      sh = (rt == 0) || (rt == m_div);
      m_win <= w; m_ratio <= rt; m_t <= 0; m_act <= 1;
      m_busy <= 1; m_rej <= (rt == 0); m_short <= sh;
      m_T <= sh ? 1 : G + 1 + S;
      if (!sh) m_en <= 0;
    end
  end

  logic [7:0] p_div;
  bit         p_en;
  bit         p_ok = 0;

  always @(negedge clk_ref) begin
    chk("grant", int'(grant), int'(m_grant));
    chk("err", int'(err), int'(m_err));
    chk("div_ratio", int'(div_ratio), int'(m_div));
    chk("clk_en", int'(clk_en), int'(m_en));
    chk("busy", int'(busy), int'(m_busy));
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    if (rst_n && p_ok && div_ratio != p_div)
      chk("div_change_gated", int'(clk_en | p_en), 0);
    p_ok  <= rst_n;
    p_div <= div_ratio;
    p_en  <= clk_en;
  end

  // Reference divider used to measure the resulting output period.
  logic [7:0] d_cnt;
  always @(posedge clk_ref) begin
    if (!clk_en) d_cnt <= '0;
    else if (d_cnt + 8'd1 >= div_ratio) d_cnt <= '0;
    else d_cnt <= d_cnt + 8'd1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int lowc, t1, t2, n, got;
  int ord [5];
  int rrd [5];
  int exp_ord [5] = '{0, 1, 2, 3, 0};
  int exp_rrd [5] = '{3, 4, 5, 6, 3};
  logic [3:0] gw;

  initial begin
    rst_n = 0;
    req = '0;
    for (int i = 0; i < 4; i++) ratios[i] = '0;
    repeat (2) @(negedge clk_ref);
    chk("rst_div", int'(div_ratio), 2);
    chk("rst_en", int'(clk_en), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1;
    @(negedge clk_ref);
    chk("boot_en", int'(clk_en), 1);
    @(negedge clk_ref);

    ratios[1] = 8'd7;
    req = 4'b0010;
    lowc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_ref);
      if (!clk_en) lowc++;
      if (k == 1) chk("sc_div_e1", int'(div_ratio), 2);
      if (k == 2) chk("sc_div_e2", int'(div_ratio), 7);
      if (k == 6) chk("sc_grant_e6", int'(grant), 0);
      if (k == 7) begin
        chk("sc_grant_e7", int'(grant), 2);
        req = '0;
      end
    end
    chk("sc_en_low", lowc, 3);

    t1 = -1;
    t2 = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_ref);
      if (d_cnt == 0) begin
        if (t1 < 0) t1 = int'($time);
        else if (t2 < 0) t2 = int'($time);
      end
    end
    chk("div_period_ns", t2 - t1, 70);

    ratios[2] = 8'd0;
    req = 4'b0100;
    lowc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_ref);
      if (!clk_en) lowc++;
      if (k == 0) chk("rej_busy", int'(busy), 1);
      if (k == 1) begin
        chk("rej_grant", int'(grant), 4);
        chk("rej_err", int'(err), 1);
        req = '0;
      end
    end
    chk("rej_en_low", lowc, 0);

    ratios[3] = 8'd7;
    req = 4'b1000;
    lowc = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_ref);
      if (!clk_en) lowc++;
      if (k == 1) begin
        chk("noop_grant", int'(grant), 8);
        chk("noop_err", int'(err), 0);
        req = '0;
      end
      if (k == 2) chk("noop_busy_done", int'(busy), 0);
    end
    chk("noop_en_low", lowc, 0);

    ratios[0] = 8'd3; ratios[1] = 8'd4;
    ratios[2] = 8'd5; ratios[3] = 8'd6;
    req = 4'b1111;
    n = 0;
    for (int k = 0; k < 80 && n < 5; k++) begin
      @(negedge clk_ref);
      if (grant != 0) begin
        ord[n] = 0;
        for (int i = 0; i < 4; i++) if (grant[i]) ord[n] = i;
        rrd[n] = int'(div_ratio);
        n++;
        if (n == 5) req = '0;
      end
    end
    chk("rr_count", n, 5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", ord[i], exp_ord[i]);
      chk("rr_ratio", rrd[i], exp_rrd[i]);
    end

    ratios[2] = 8'd9;
    ratios[3] = 8'd5;
    req = 4'b1100;
    got = 0;
    for (int k = 0; k < 6 && got == 0; k++) begin
      @(negedge clk_ref);
      if (!clk_en) got = 1;
    end
    chk("ar_gate_seen", got, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_div", int'(div_ratio), 2);
    chk("ar_en", int'(clk_en), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_grant", int'(grant), 0);
    repeat (2) @(negedge clk_ref);
    rst_n = 1;
    gw = '0;
    for (int k = 0; k < 20 && gw == 0; k++) begin
      @(negedge clk_ref);
      gw = grant;
    end
    chk("ar_regrant", int'(gw), 4);
    chk("ar_new_div", int'(div_ratio), 9);
    req = '0;
    repeat (3) @(negedge clk_ref);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencer and arbiter for the integer clock divider (`clk_div`). It accepts division-ratio change requests from up to `num_req` requesters and picks one by round-robin. For the winner it gates the divider off, loads the new ratio, re-enables and waits a settle window, then acknowledges. The block sits between the software/config requesters and the divider's `clk_en` / `div_ratio` inputs, and is the only driver of those inputs.

## Interface
- `div_ratio_wd`, 8 — width of every ratio field; matches the divider.
- `num_req`, 4 — number of requesters, ≥2.
- `default_ratio`, 2 — ratio driven out of reset.
- `gate_cycles`, 2 — cycles `clk_en` is held low before the new ratio loads; ≥1.
- `settle_cycles`, 4 — cycles `clk_en` is high after the load before grant; ≥1.

Ports (clock and reset first):
- `clk_ref`  in  1  — the one clock; the same reference clock the divider uses.
- `rst_n`  in  1  — asynchronous active-low reset.
- `req`  in  num_req  — request bit per requester; level, held until grant.
- `req_ratio`  in  num_req*div_ratio_wd  — requester i ratio at `[i*div_ratio_wd +: div_ratio_wd]`; held stable while `req[i]` is high.
- `grant`  out  num_req  — one-hot, one-cycle acknowledge of the completed request.
- `err`  out  1  — one-cycle pulse coincident with `grant` when the request was rejected.
- `div_ratio`  out  div_ratio_wd  — ratio to the divider.
- `clk_en`  out  1  — enable to the divider.
- `busy`  out  1  — high from arbitration through the `grant` cycle.

## Operation
- **States:**
  - BOOT: reset state.
  - IDLE.
  - GATE: counts `gate_cycles`.
  - LOAD: lasts 1 cycle.
  - SETTLE: counts `settle_cycles`.
  - ACK: lasts 1 cycle.
- **Reset values:** `div_ratio`=`default_ratio`, `clk_en`=0, `grant`=0, `err`=0, `busy`=0, round-robin pointer=0, state BOOT.
- **BOOT → IDLE** on the first edge after reset release; `clk_en` goes to 1 on that edge.
- **IDLE, `req` nonzero:**
  - Winner is the first set bit searching upward from the pointer, with wrap.
  - Winner index and its ratio are latched on that edge.
  - `busy` goes to 1.
- **Next state from IDLE:**
  - Latched ratio = 0: → ACK with `err`=1. `div_ratio` and `clk_en` are not touched.
  - Latched ratio = current `div_ratio`: → ACK directly, no gating.
  - Otherwise: → GATE, and `clk_en` goes to 0.
- **GATE → LOAD** after `gate_cycles` cycles. Entering LOAD writes `div_ratio`. `clk_en` stays 0.
- **LOAD → SETTLE.** `clk_en` goes to 1 on entry. After `settle_cycles` cycles → ACK.
- **ACK:**
  - `grant[winner]`=1 for exactly 1 cycle.
  - Pointer becomes (winner+1) mod `num_req`.
  - Next edge → IDLE with `grant`=0, `err`=0, `busy`=0.
- **Requests during a transaction** are ignored until IDLE; no preemption.
- **Winner drops `req` mid-transaction:** the sequence completes and `grant` still pulses.
- **Other ratio values:** ratio 1 is legal and loaded as-is; only 0 is rejected.
- **Width rules:** all counters are sized with `$clog2(max(gate_cycles, settle_cycles)+1)`. Counters never wrap inside a state.
- **`rst_n` low mid-transaction:** all outputs return to reset values asynchronously. The in-flight request gets no `grant`.

## Timing
- Outputs are registered (Moore); there is no combinational path from `req` to any output.
- **Full change**, with the IDLE sampling edge as E0:
  - `clk_en` falls after E0.
  - `div_ratio` updates after E(`gate_cycles`).
  - `clk_en` rises after E(`gate_cycles`+1).
  - `grant` is high after E(`gate_cycles`+1+`settle_cycles`). With defaults that is E7.
- **`div_ratio` change window:** `div_ratio` never changes while `clk_en`=1. It changes only with `clk_en` low, at least 1 cycle after the fall and 1 cycle before the rise.
- **Same-ratio or rejected request:** `grant` is high after E1. `clk_en` stays 1 throughout.
- **Back-to-back:** a request pending at the IDLE return is sampled on the next edge. The minimum gap between grants is 1 IDLE cycle.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles, then release.
  - During reset: `div_ratio`=2, `clk_en`=0, `grant`=0, `busy`=0.
  - `clk_en`=1 one edge after release.
- **Single change:** `req[1]` with ratio 7.
  - `clk_en` is low exactly 3 cycles.
  - `div_ratio`=7 on the 2nd edge after the sample.
  - `grant`=4'b0010 on the 7th edge.
  - The divider's `clk_out` period then measures 70 ns on the 10 ns reference.
- **Round-robin:** `req`=4'b1111 held with distinct ratios 3, 4, 5, 6.
  - Grants arrive in order 0, 1, 2, 3, 0.
  - `div_ratio` follows 3, 4, 5, 6.
- **Reject and no-op:**
  - Ratio 0: `grant`+`err` after 1 edge, `clk_en` never falls.
  - Ratio equal to the current one: `grant` after 1 edge, `err`=0.
- **Async reset mid-GATE:** assert `rst_n`=0 with `clk_en` low.
  - Outputs reset immediately; no `grant` for the aborted request.
  - After release, that requester wins first and completes normally.
- **Stability checker (whole run):** assert `div_ratio` changes only while `clk_en`=0, and `grant` is always one-hot or zero.
